// File: rtl/pattern_serializer.sv
// MSB-first serializer: loads pattern[len-1:0] and shifts it out one bit per clock.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module pattern_serializer #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   len,
    output logic               ready,
    output logic               o,
    output logic               o_valid,
    output logic               done
);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t             state, state_n;
    logic [MAX_LEN-1:0] sreg, sreg_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               o_n, o_valid_n, done_n;
    logic [CNT_W-1:0]   eff_len;
    logic [MAX_LEN-1:0] aligned;
`ifdef SERIALIZER_PARITY_EN
    logic               par, par_n;
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            o       <= 1'b0;
            o_valid <= 1'b0;
            done    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            sreg    <= sreg_n;
            cnt     <= cnt_n;
            o       <= o_n;
            o_valid <= o_valid_n;
            done    <= done_n;
`ifdef SERIALIZER_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        eff_len   = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;
        // Left-justify the valid field so the next bit is always the register MSB.
        aligned   = pattern << (CNT_W'(MAX_LEN) - eff_len);
        state_n   = state;
        sreg_n    = sreg;
        cnt_n     = cnt;
        o_n       = 1'b0;
        o_valid_n = 1'b0;
        done_n    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                if (load && (len != '0)) begin
                    state_n   = SHIFT;
                    o_n       = aligned[MAX_LEN-1];
                    o_valid_n = 1'b1;
                    sreg_n    = aligned << 1;
                    cnt_n     = eff_len - CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
                    par_n     = aligned[MAX_LEN-1];
`endif
                end
            end
            SHIFT: begin
                // cnt holds the number of bits still to present after the current one.
                if (cnt != '0) begin
                    o_n       = sreg[MAX_LEN-1];
                    o_valid_n = 1'b1;
                    sreg_n    = sreg << 1;
                    cnt_n     = cnt - CNT_W'(1);
`ifdef SERIALIZER_PARITY_EN
                    par_n     = par ^ sreg[MAX_LEN-1];
`endif
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    state_n   = PARITY;
                    o_n       = par;
                    o_valid_n = 1'b1;
`else
                    state_n   = DONE;
                    done_n    = 1'b1;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: stimulus pushes cycle-stamped expected
// bits and done pulses; a negedge monitor pops and compares them.
module tb_pattern_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        ready, o, o_valid, done;

    typedef struct {
        bit          is_done;
        bit          val;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned passed = 0;

`ifdef SERIALIZER_PARITY_EN
    localparam int unsigned PAR_CYC = 1;
`else
    localparam int unsigned PAR_CYC = 0;
`endif

    pattern_serializer #(.MAX_LEN(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .pattern (pattern),
        .len     (len),
        .ready   (ready),
        .o       (o),
        .o_valid (o_valid),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Monitor: every valid bit or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid || done) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_output: o_valid=%0b done=%0b o=%0b, expected nothing (cycle %0d)",
                             o_valid, done, o, cyc);
                end else begin
                    e = q.pop_front();
                    if ((done == e.is_done) && (o_valid == !e.is_done) &&
                        (e.is_done || (o == e.val)) && (cyc == e.cyc))
                        passed++;
                    else
                        $display("FAIL stream: got o_valid=%0b done=%0b o=%0b at cycle %0d, expected %s val=%0b at cycle %0d",
                                 o_valid, done, o, cyc, e.is_done ? "done" : "bit", e.val, e.cyc);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                total++;
                e = q.pop_front();
                $display("FAIL missing_output: got nothing at cycle %0d, expected %s val=%0b",
                         cyc, e.is_done ? "done" : "bit", e.val);
            end
            if (!o_valid) chk("o_zero_when_invalid", {31'd0, o}, 32'd0);
        end
    end

    task automatic wait_ready();
        int unsigned t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    // exp_bits holds the hand-computed transmitted bits right-aligned, n of them.
    task automatic send(input logic [15:0] pat, input logic [4:0] ln,
                        input logic [15:0] exp_bits, input int unsigned n, input bit junk);
        int unsigned n0;
        int unsigned tgt;
        bit          p = 1'b0;
        wait_ready();
        load    = 1'b1;
        pattern = pat;
        len     = ln;
        @(posedge clk);
        #1;
        n0 = cyc;
        for (int i = int'(n) - 1; i >= 0; i--) begin
            q.push_back('{1'b0, exp_bits[i], n0 + n - 1 - i});
            p ^= exp_bits[i];
        end
        if (PAR_CYC != 0) q.push_back('{1'b0, p, n0 + n});
        q.push_back('{1'b1, 1'b0, n0 + n + PAR_CYC});
        chk("ready_busy", {31'd0, ready}, 32'd0);
        if (junk) begin
            pattern = ~pat;
            len     = 5'd2;
            repeat (3) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        load = 1'b0;
        tgt  = n0 + n + PAR_CYC + 1;
        while (cyc < tgt) @(negedge clk);
        chk("ready_after_done", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        pattern = '0;
        len     = '0;
        #1;
        chk("reset_o", {31'd0, o}, 32'd0);
        chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(16'h000D, 5'd4, 16'h000D, 4, 1'b0);
        send(16'b0000011011011010, 5'd11, 16'b0000011011011010, 11, 1'b0);

        // len==0 must be ignored.
        load    = 1'b1;
        len     = 5'd0;
        pattern = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("len0_ready", {31'd0, ready}, 32'd1);
            chk("len0_o_valid", {31'd0, o_valid}, 32'd0);
        end
        load = 1'b0;

        // Load during SHIFT with new data is ignored.
        send(16'h000D, 5'd4, 16'h000D, 4, 1'b1);
        send(16'hFFFE, 5'd1, 16'h0000, 1, 1'b0);
        send(16'hA5C3, 5'd16, 16'hA5C3, 16, 1'b0);
        send(16'h8001, 5'd20, 16'h8001, 16, 1'b0);
        send(16'hFFF2, 5'd3, 16'h0002, 3, 1'b0);

        // Asynchronous reset after bit 2 of 4: 1011 -> only 1,0 appear.
        wait_ready();
        load    = 1'b1;
        pattern = 16'h000B;
        len     = 5'd4;
        @(posedge clk);
        #1;
        q.push_back('{1'b0, 1'b1, cyc});
        q.push_back('{1'b0, 1'b0, cyc + 1});
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_o", {31'd0, o}, 32'd0);
        chk("abort_o_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_queue_drained", q.size(), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_done", {31'd0, done}, 32'd0);

        send(16'h000D, 5'd4, 16'h000D, 4, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
